// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, command set, status reply and the
// slave state encoding used across the SPI slave slice.
package spi_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] CMD_STATUS    = 8'h06;
    localparam logic [7:0] CMD_LED       = 8'hA1;
    localparam logic [7:0] CMD_LEG_FIRST = 8'hA3;
    localparam logic [7:0] CMD_LEG_LAST  = 8'hAE;
    localparam logic [7:0] STATUS_REPLY  = 8'hD4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_leg_cmd(input logic [7:0] cmd);
        return (cmd >= CMD_LEG_FIRST) && (cmd <= CMD_LEG_LAST);
    endfunction

endpackage

// File: rtl/spi_sync_module.sv
// Multi-flop synchronizer for one asynchronous input, with one-clk rise and
// fall strobes decoded from its last two stages.
module spi_sync_module #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: newest sample enters at bit 0, oldest leaves at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_module.sv
// Mode-0 SPI slave: oversamples SCLK/MOSI/NCS on clk, receives MSB-first bytes
// and optionally transmits a caller-supplied byte in the same transfer.
module spi_slave_module
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iSCLK,
    input  logic              iMOSI,
    input  logic              iNCS,
    output logic              oMISO,
    output logic              oMISO_En,
    input  logic              iCall,
    input  logic [BYTE_W-1:0] iData,
    output logic [1:0]        oDone,
    output logic [BYTE_W-1:0] oData
);

    localparam logic [3:0] LAST_BIT = 4'(BYTE_W - 1);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic ncs_s, ncs_rise_s, ncs_fall_s;
    logic sync_unused_s;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              mode_q, mode_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [1:0]        done_q, done_d;

    spi_sync_module #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(iSCLK),
        .q_o(sclk_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_module #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(iMOSI),
        .q_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
    );

    spi_sync_module #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(iNCS),
        .q_o(ncs_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
    );

    // Only the SCLK edges and the NCS falling edge steer the FSM.
    assign sync_unused_s = sclk_s ^ mosi_rise_s ^ mosi_fall_s ^ ncs_rise_s;

    // Next-state logic; NCS high outside IDLE aborts any byte in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        mode_d  = mode_q;
        data_d  = data_q;
        done_d  = 2'b00;
        if (ncs_s && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            tx_d    = {BYTE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
                    tx_d  = {BYTE_W{1'b0}};
                    if (ncs_fall_s) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    tx_d = iCall ? iData : {BYTE_W{1'b0}};
                    if (sclk_rise_s) begin
                        mode_d  = iCall;
                        rx_d    = {{(BYTE_W-1){1'b0}}, mosi_s};
                        cnt_d   = 4'd1;
                        state_d = ST_SHIFT;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise_s) begin
                        rx_d = {rx_q[BYTE_W-2:0], mosi_s};
                        // The byte completes on the last rise: publish while in DONE.
                        if (cnt_q == LAST_BIT) begin
                            cnt_d   = 4'd0;
                            data_d  = {rx_q[BYTE_W-2:0], mosi_s};
                            done_d  = mode_q ? 2'b10 : 2'b01;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (sclk_fall_s) begin
                        tx_d = {tx_q[BYTE_W-2:0], 1'b0};
                    end else begin
                        tx_d = tx_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_ARM;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            tx_q    <= {BYTE_W{1'b0}};
            rx_q    <= {BYTE_W{1'b0}};
            mode_q  <= 1'b0;
            data_q  <= {BYTE_W{1'b0}};
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign oMISO    = tx_q[BYTE_W-1];
    assign oMISO_En = ~ncs_s;
    assign oDone    = done_q;
    assign oData    = data_q;

endmodule

// File: tb/tb_spi_slave_module.sv
// Bench for spi_slave_module: directed frames followed by random back-to-back
// bytes, with aborts, checked against a byte-level transaction model.
module tb_spi_slave_module;

    localparam int SYNC = 3;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iSCLK = 1'b0;
    logic       iMOSI = 1'b0;
    logic       iNCS = 1'b1;
    logic       oMISO;
    logic       oMISO_En;
    logic       iCall = 1'b0;
    logic [7:0] iData = 8'h00;
    logic [1:0] oDone;
    logic [7:0] oData;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [7:0] last_data = 8'h00;
    logic [1:0] prev_done = 2'b00;

    spi_slave_module #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .iSCLK(iSCLK), .iMOSI(iMOSI), .iNCS(iNCS),
        .oMISO(oMISO), .oMISO_En(oMISO_En), .iCall(iCall), .iData(iData),
        .oDone(oDone), .oData(oData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: never 2'b11, never longer than one clk, count every pulse.
    always @(negedge clk) begin
        chk("done_not_11", {30'd0, oDone == 2'b11}, 32'd0);
        if (oDone != 2'b00) begin
            pulses++;
            chk("done_one_clk", {30'd0, prev_done}, 32'd0);
        end
        prev_done = oDone;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        iNCS = 1'b0;
        wait_clk(HALF);
        chk("miso_en_low_ncs", {31'd0, oMISO_En}, 32'd1);
    endtask

    task automatic end_frame();
        wait_clk(4);
        iNCS = 1'b1;
        wait_clk(8);
        chk("miso_en_idle", {31'd0, oMISO_En}, 32'd0);
        chk("miso_idle", {31'd0, oMISO}, 32'd0);
        chk("pulse_count", pulses, exp_pulses);
        chk("data_hold", {24'd0, oData}, {24'd0, last_data});
    endtask

    // Master transfer of nbits MSB-first bits; full bytes check pulse, data and MISO.
    task automatic send_byte(input logic [7:0] mosi, input int nbits, input logic call,
                             input logic [7:0] data, input logic scramble);
        logic [7:0] miso_bits;
        logic [7:0] mask;
        logic [7:0] exp_miso;
        logic [1:0] obs_done;
        logic [7:0] obs_data;
        logic       found;
        int         waited;
        miso_bits = 8'h00;
        found     = 1'b0;
        obs_done  = 2'b00;
        obs_data  = 8'h00;
        iCall = call;
        iData = data;
        for (int b = 0; b < nbits; b++) begin
            iMOSI = mosi[7-b];
            wait_clk(HALF);
            miso_bits = {miso_bits[6:0], oMISO};
            iSCLK = 1'b1;
            waited = 0;
            if (b == 7) begin
                for (int k = 1; k <= SYNC + 2; k++) begin
                    if (!found) begin
                        @(negedge clk);
                        waited = k;
                        if (oDone != 2'b00) begin
                            found    = 1'b1;
                            obs_done = oDone;
                            obs_data = oData;
                        end
                    end
                end
            end
            wait_clk(HALF - waited);
            iSCLK = 1'b0;
            if (b == 0 && scramble) begin
                iCall = 1'($urandom);
                iData = 8'($urandom);
            end
        end
        miso_bits = miso_bits << (8 - nbits);
        mask      = 8'hFF << (8 - nbits);
        exp_miso  = call ? data : 8'h00;
        chk("miso_bits", {24'd0, miso_bits & mask}, {24'd0, exp_miso & mask});
        if (nbits == 8) begin
            exp_pulses++;
            last_data = mosi;
            chk("done_latency", {31'd0, found}, 32'd1);
            chk("done_kind", {30'd0, obs_done}, {30'd0, call ? 2'b10 : 2'b01});
            chk("rx_data", {24'd0, obs_data}, {24'd0, mosi});
        end
    endtask

    initial begin
        int nbytes;
        int nb;
        // Reset and idle.
        wait_clk(3);
        chk("rst_miso", {31'd0, oMISO}, 32'd0);
        chk("rst_miso_en", {31'd0, oMISO_En}, 32'd0);
        chk("rst_done", {30'd0, oDone}, 32'd0);
        chk("rst_data", {24'd0, oData}, 32'd0);
        rst_n = 1'b1;
        wait_clk(10);
        chk("idle_outputs", {20'd0, oMISO, oMISO_En, oDone, oData}, 32'd0);

        // Status command then reply byte in one frame.
        start_frame();
        send_byte(8'h06, 8, 1'b0, 8'hD4, 1'b0);
        send_byte(8'h00, 8, 1'b1, 8'hD4, 1'b0);
        end_frame();

        // Back-to-back receive then transmit.
        start_frame();
        send_byte(8'hA3, 8, 1'b0, 8'h55, 1'b0);
        send_byte(8'h7F, 8, 1'b1, 8'h00, 1'b0);
        end_frame();

        // Abort after five bits, then a clean frame.
        start_frame();
        send_byte(8'hFF, 5, 1'b0, 8'h00, 1'b0);
        end_frame();
        start_frame();
        send_byte(8'h5A, 8, 1'b0, 8'h00, 1'b0);
        end_frame();

        // Reset mid-byte, then NCS high-low and a fresh byte.
        start_frame();
        send_byte(8'hC3, 3, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst_outputs", {20'd0, oMISO, oMISO_En, oDone, oData}, 32'd0);
        iNCS = 1'b1;
        last_data = 8'h00;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(8);
        start_frame();
        send_byte(8'h3C, 8, 1'b0, 8'h00, 1'b0);
        end_frame();

        // Random frames with random call/data, in-byte iCall changes and aborts.
        nbytes = 0;
        while (nbytes < 24) begin
            start_frame();
            nb = int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    send_byte(8'($urandom), int'($urandom_range(1, 7)), 1'($urandom), 8'($urandom), 1'b1);
                    break;
                end else begin
                    send_byte(8'($urandom), 8, 1'($urandom), 8'($urandom), 1'b1);
                end
            end
            end_frame();
            nbytes += nb;
        end

        chk("final_pulse_count", pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
